// File: rtl/fetch_pkg.sv
// Shared types for the fetch request path: FSM states, bus widths and the
// bundle of registered sequencer outputs.
package fetch_pkg;

    localparam int ADDR_W = 64;
    localparam int LEN_W  = 36;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT,
        ISSUE,
        UPD,
        DRAIN
    } seq_state_e;

    // Every registered output of the sequencer, so the FSM can update them as one value
    typedef struct packed {
        logic              cmd_done;
        logic              inc_initialize;
        logic [ADDR_W-1:0] inc_address;
        logic [LEN_W-1:0]  inc_length;
        logic              inc_init_complete;
        logic              inc_update;
        logic [LEN_W-1:0]  inc_size;
        logic              req_valid;
        logic [ADDR_W-1:0] req_address;
        logic [LEN_W-1:0]  req_bytes;
    } seq_out_t;

endpackage

// File: rtl/fetch_request_sequencer_if.sv
// Descriptor, incrementer-control, burst-request and response signals of the
// fetch request sequencer. The master modport is the sequencer side.
interface fetch_request_sequencer_if;
    import fetch_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_address;
    logic [LEN_W-1:0]  cmd_length;
    logic              cmd_done;

    logic              inc_initialize;
    logic [ADDR_W-1:0] inc_address;
    logic [LEN_W-1:0]  inc_length;
    logic              inc_init_complete;
    logic              inc_update;
    logic [LEN_W-1:0]  inc_size;
    logic [ADDR_W-1:0] inc_cur_address;
    logic [LEN_W-1:0]  inc_cur_length;
    logic              inc_valid;
    logic              inc_complete;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_address;
    logic [LEN_W-1:0]  req_bytes;

    logic              rsp_done;
    logic              protocol_err;

    modport master (
        input  cmd_valid, cmd_address, cmd_length,
        output cmd_ready, cmd_done,
        output inc_initialize, inc_address, inc_length, inc_init_complete,
        output inc_update, inc_size,
        input  inc_cur_address, inc_cur_length, inc_valid, inc_complete,
        output req_valid, req_address, req_bytes,
        input  req_ready, rsp_done,
        output protocol_err
    );

    modport slave (
        output cmd_valid, cmd_address, cmd_length,
        input  cmd_ready, cmd_done,
        input  inc_initialize, inc_address, inc_length, inc_init_complete,
        input  inc_update, inc_size,
        output inc_cur_address, inc_cur_length, inc_valid, inc_complete,
        input  req_valid, req_address, req_bytes,
        output req_ready, rsp_done,
        input  protocol_err
    );

endinterface

// File: rtl/burst_size_calc.sv
// Combinational burst sizer: the smaller of remaining length, the burst cap
// and the distance to the next page boundary. Shared with the write path.
module burst_size_calc
    import fetch_pkg::*;
#(
    parameter int BURST_BYTES    = 512,
    parameter int BOUNDARY_BYTES = 4096
) (
    input  logic [$clog2(BOUNDARY_BYTES)-1:0] offset,
    input  logic [LEN_W-1:0]                  length,
    output logic [LEN_W-1:0]                  size
);

    localparam logic [LEN_W-1:0] BURST_L = LEN_W'(BURST_BYTES);
    localparam logic [LEN_W-1:0] BOUND_L = LEN_W'(BOUNDARY_BYTES);

    logic [LEN_W-1:0] to_boundary;
    logic [LEN_W-1:0] cap;

    always_comb begin
        to_boundary = BOUND_L - LEN_W'(offset);
        cap         = (to_boundary < BURST_L) ? to_boundary : BURST_L;
        size        = (length < cap) ? length : cap;
    end

endmodule

// File: rtl/fetch_request_sequencer.sv
// Drives the address incrementer to split one fetch descriptor into
// page-safe read bursts, bounding in-flight bursts and reporting completion.
module fetch_request_sequencer
    import fetch_pkg::*;
#(
    parameter int BURST_BYTES     = 512,
    parameter int BOUNDARY_BYTES  = 4096,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_W           = 3
) (
    input logic clk,
    input logic rst,
    fetch_request_sequencer_if.master bus
);

    localparam int              OFF_W   = $clog2(BOUNDARY_BYTES);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    seq_state_e       state_q, state_d;
    seq_out_t         out_q, out_d;
    logic [OUT_W-1:0] outstanding_q;
    logic             protocol_err_q;
    logic [LEN_W-1:0] burst_size;
    logic             req_fire;

    burst_size_calc #(
        .BURST_BYTES   (BURST_BYTES),
        .BOUNDARY_BYTES(BOUNDARY_BYTES)
    ) u_size (
        .offset(bus.inc_cur_address[OFF_W-1:0]),
        .length(bus.inc_cur_length),
        .size  (burst_size)
    );

    assign req_fire = out_q.req_valid & bus.req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; all state and outputs clear, dropping any pending request.
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case can infer a latch.
        state_d              = state_q;
        out_d                = out_q;
        out_d.cmd_done       = 1'b0;
        out_d.inc_initialize = 1'b0;
        out_d.inc_update     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    out_d.inc_initialize    = 1'b1;
                    out_d.inc_address       = bus.cmd_address;
                    out_d.inc_length        = bus.cmd_length;
                    out_d.inc_init_complete = (bus.cmd_length == '0);
                    state_d                 = INIT;
                end
            end
            INIT: state_d = WAIT;
            WAIT: begin
                if (bus.inc_valid && bus.inc_complete) begin
                    state_d = DRAIN;
                end else if (bus.inc_valid && (outstanding_q < MAX_OUT)) begin
                    out_d.req_valid   = 1'b1;
                    out_d.req_address = bus.inc_cur_address;
                    out_d.req_bytes   = burst_size;
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.req_ready) begin
                    out_d.req_valid  = 1'b0;
                    out_d.inc_update = 1'b1;
                    out_d.inc_size   = out_q.req_bytes;
                    state_d          = UPD;
                end
            end
            UPD: state_d = WAIT;
            DRAIN: begin
                if (outstanding_q == '0) begin
                    out_d.cmd_done = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A burst issued and a response in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q  <= '0;
            protocol_err_q <= 1'b0;
        end else if (req_fire && !bus.rsp_done) begin
            outstanding_q <= outstanding_q + OUT_W'(1);
        end else if (!req_fire && bus.rsp_done) begin
            if (outstanding_q == '0) protocol_err_q <= 1'b1;
            else                     outstanding_q  <= outstanding_q - OUT_W'(1);
        end
    end

    assign bus.cmd_ready         = (state_q == IDLE);
    assign bus.cmd_done          = out_q.cmd_done;
    assign bus.inc_initialize    = out_q.inc_initialize;
    assign bus.inc_address       = out_q.inc_address;
    assign bus.inc_length        = out_q.inc_length;
    assign bus.inc_init_complete = out_q.inc_init_complete;
    assign bus.inc_update        = out_q.inc_update;
    assign bus.inc_size          = out_q.inc_size;
    assign bus.req_valid         = out_q.req_valid;
    assign bus.req_address       = out_q.req_address;
    assign bus.req_bytes         = out_q.req_bytes;
    assign bus.protocol_err      = protocol_err_q;

endmodule

// File: tb/tb_fetch_request_sequencer.sv
// Bench for fetch_request_sequencer: incrementer and responder models, a
// descriptor-splitting reference model with per-cycle compare, directed tests.
module tb_fetch_request_sequencer;
    import fetch_pkg::*;

    localparam int BURST = 512;
    localparam int BOUND = 4096;
    localparam int MAXO  = 2;

    typedef struct {
        logic [63:0] addr;
        logic [35:0] bytes;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_request_sequencer_if bus ();

    fetch_request_sequencer #(
        .BURST_BYTES    (BURST),
        .BOUNDARY_BYTES (BOUND),
        .MAX_OUTSTANDING(MAXO),
        .OUT_W          (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic auto_en = 1'b1;
    logic auto_rsp = 1'b0;
    logic man_rsp = 1'b0;
    assign bus.rsp_done = auto_rsp | man_rsp;

    req_t exp_q[$];
    req_t log_q[$];
    int   hs_total = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   cmd_cyc  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference split of a descriptor into bursts
    task automatic expect_requests(input logic [63:0] a, input logic [35:0] l);
        logic [35:0] sz;
        logic [35:0] room;
        while (l != 0) begin
            room = 36'(BOUND) - 36'(a % BOUND);
            sz   = l;
            if (sz > 36'(BURST)) sz = 36'(BURST);
            if (sz > room) sz = room;
            exp_q.push_back('{addr: a, bytes: sz});
            a = a + 64'(sz);
            l = l - sz;
        end
    endtask

    // Address incrementer: valid one cycle after initialize, five cycles after an update
    logic        m_r, m_i, m_u, m_ic;
    logic [63:0] m_a;
    logic [35:0] m_l, m_s;
    int          m_cnt;
    initial begin
        bus.inc_valid = 0; bus.inc_complete = 0;
        bus.inc_cur_address = '0; bus.inc_cur_length = '0;
        m_cnt = 0;
        forever begin
            @(negedge clk);
            m_r = rst; m_i = bus.inc_initialize; m_u = bus.inc_update;
            m_a = bus.inc_address; m_l = bus.inc_length; m_ic = bus.inc_init_complete; m_s = bus.inc_size;
            @(posedge clk); #1;
            if (m_r) begin
                bus.inc_valid = 0; bus.inc_complete = 0; m_cnt = 0;
            end else if (m_i) begin
                bus.inc_cur_address = m_a; bus.inc_cur_length = m_l;
                bus.inc_complete = m_ic || (m_l == 0); bus.inc_valid = 1; m_cnt = 0;
            end else if (m_u) begin
                bus.inc_cur_address = bus.inc_cur_address + 64'(m_s);
                bus.inc_cur_length  = bus.inc_cur_length - m_s;
                bus.inc_valid = 0; m_cnt = 4;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    bus.inc_valid = 1;
                    bus.inc_complete = (bus.inc_cur_length == 0);
                end
            end
        end
    end

    // Memory responder: one rsp_done three cycles after each accepted request
    int   due_q[$];
    logic r_h, r_r;
    int   r_c;
    initial forever begin
        @(negedge clk);
        r_h = bus.req_valid && bus.req_ready; r_r = rst; r_c = cyc;
        @(posedge clk); #1;
        auto_rsp = 1'b0;
        if (r_r) due_q.delete();
        else begin
            if (r_h && auto_en) due_q.push_back(r_c + 3);
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                auto_rsp = 1'b1;
                void'(due_q.pop_front());
            end
        end
    end

    // Per-cycle compare against the reference model
    int          out_m = 0;
    logic        err_m = 0;
    logic        p_hs = 0, p_stall = 0;
    logic [63:0] p_addr = '0;
    logic [35:0] p_bytes = '0;
    logic        hs, rsp;
    req_t        e;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            out_m = 0; err_m = 0; exp_q.delete(); p_hs = 0; p_stall = 0;
        end else begin
            hs  = bus.req_valid && bus.req_ready;
            rsp = bus.rsp_done;
            check("inc_update", bus.inc_update, p_hs);
            if (p_hs) check("inc_size", bus.inc_size, p_bytes);
            if (p_stall) begin
                check("stall_valid", bus.req_valid, 1);
                check("stall_addr", bus.req_address, p_addr);
                check("stall_bytes", bus.req_bytes, p_bytes);
            end
            check("protocol_err", bus.protocol_err, err_m);
            if (hs) begin
                check("issue_over_limit", out_m >= MAXO, 0);
                if (exp_q.size() == 0) check("unexpected_req", hs, 0);
                else begin
                    e = exp_q.pop_front();
                    check("req_address", bus.req_address, e.addr);
                    check("req_bytes", bus.req_bytes, e.bytes);
                end
                log_q.push_back('{addr: bus.req_address, bytes: bus.req_bytes});
                hs_total++;
            end
            if (bus.cmd_done) begin
                check("done_ready", bus.cmd_ready, 1);
                check("done_early", (exp_q.size() != 0) || (out_m != 0), 0);
                done_cnt++;
                done_cyc = cyc;
            end
            if (hs && !rsp) out_m++;
            else if (!hs && rsp) begin
                if (out_m == 0) err_m = 1;
                else out_m--;
            end
            p_hs = hs; p_addr = bus.req_address; p_bytes = bus.req_bytes;
            p_stall = bus.req_valid && !bus.req_ready;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [35:0] l);
        bit ok = 0;
        expect_requests(a, l);
        bus.cmd_valid = 1; bus.cmd_address = a; bus.cmd_length = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin ok = 1; cmd_cyc = cyc; end
            tick();
        end
        bus.cmd_valid = 0;
        check("cmd_accept", ok, 1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int start = done_cnt;
        int i = 0;
        while (done_cnt == start && i < budget) begin tick(); i++; end
        repeat (3) tick();
        check(name, done_cnt - start, 1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = bus.req_valid;
            if (!seen) tick();
        end
        check(name, seen, 1);
    endtask

    task automatic check_log(input string name, input int idx, input logic [63:0] a, input logic [35:0] b);
        if (idx >= log_q.size()) check(name, log_q.size(), idx + 1);
        else begin
            check(name, log_q[idx].addr, a);
            check(name, log_q[idx].bytes, b);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_valid"}, bus.req_valid, 0);
        check({tag, "_req_address"}, bus.req_address, 0);
        check({tag, "_req_bytes"}, bus.req_bytes, 0);
        check({tag, "_inc_init"}, bus.inc_initialize, 0);
        check({tag, "_inc_update"}, bus.inc_update, 0);
        check({tag, "_inc_addr"}, bus.inc_address, 0);
        check({tag, "_inc_size"}, bus.inc_size, 0);
        check({tag, "_cmd_done"}, bus.cmd_done, 0);
        check({tag, "_perr"}, bus.protocol_err, 0);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;
    initial begin
        bus.cmd_valid = 0; bus.cmd_address = '0; bus.cmd_length = '0; bus.req_ready = 1;
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        check_idle_outputs("reset");
        tick();

        // Three bursts, last one short
        base = log_q.size();
        send_cmd(64'h1000, 36'd1200);
        wait_done("t1_done", 120);
        check_log("t1_req0", base, 64'h1000, 36'd512);
        check_log("t1_req1", base + 1, 64'h1200, 36'd512);
        check_log("t1_req2", base + 2, 64'h1400, 36'd176);

        // Split at the page boundary
        base = log_q.size();
        send_cmd(64'h0FF0, 36'd64);
        wait_done("t2_done", 80);
        check("t2_count", log_q.size() - base, 2);
        check_log("t2_req0", base, 64'h0FF0, 36'd16);
        check_log("t2_req1", base + 1, 64'h1000, 36'd48);

        // Zero-length descriptor
        base = log_q.size();
        send_cmd(64'h2000, 36'd0);
        wait_done("t3_done", 20);
        check("t3_latency", done_cyc - cmd_cyc, 4);
        check("t3_no_req", log_q.size() - base, 0);

        // Outstanding limit, resume, simultaneous issue and response
        auto_en = 0;
        base = log_q.size();
        send_cmd(64'h0, 36'd2048);
        repeat (30) tick();
        check("t4_stall", log_q.size() - base, 2);
        bus.req_ready = 0; man_rsp = 1; tick(); man_rsp = 0;
        wait_valid("t4_resume", 20);
        tick();
        bus.req_ready = 1; man_rsp = 1; tick(); man_rsp = 0;
        for (int i = 0; i < 20 && log_q.size() - base < 4; i++) tick();
        check("t4_fourth", log_q.size() - base, 4);
        check_log("t4_req2", base + 2, 64'h400, 36'd512);
        tick(); man_rsp = 1; tick(); man_rsp = 0; tick(); man_rsp = 1; tick(); man_rsp = 0;
        wait_done("t4_done", 40);
        auto_en = 1;

        // Back-pressure on the request port, then a stray response
        base = log_q.size();
        bus.req_ready = 0;
        send_cmd(64'h5000, 36'd1024);
        for (int k = 0; k < 2; k++) begin
            wait_valid("t5_valid", 30);
            repeat (5) tick();
            bus.req_ready = 1; tick(); bus.req_ready = 0;
        end
        bus.req_ready = 1;
        wait_done("t5_done", 60);
        check_log("t5_req0", base, 64'h5000, 36'd512);
        check_log("t5_req1", base + 1, 64'h5200, 36'd512);
        man_rsp = 1; tick(); man_rsp = 0; tick();
        @(negedge clk);
        check("t5_perr", bus.protocol_err, 1);
        tick();

        // Reset while the second burst is waiting
        base = log_q.size();
        send_cmd(64'h6000, 36'd1024);
        for (int i = 0; i < 20 && log_q.size() == base; i++) tick();
        bus.req_ready = 0;
        wait_valid("t6_second", 20);
        tick();
        rst = 1; tick(); rst = 0;
        @(negedge clk);
        check_idle_outputs("t6_rst");
        tick();
        bus.req_ready = 1;
        base = log_q.size();
        send_cmd(64'h3000, 36'd100);
        wait_done("t6_done", 60);
        check("t6_count", log_q.size() - base, 1);
        check_log("t6_req", base, 64'h3000, 36'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
